data_memory_ctrl: RTL and testbench

Parametrised, clocked, byte-addressable data memory for the CPU datapath. It supports byte, halfword and word accesses with big-endian byte order: the lowest address holds the MSB. Requests use a valid/ready handshake with a programmable wait-state count. Loads can be sign- or zero-extended, and misaligned or out-of-range accesses are flagged instead of silently wrapping. It sits between the CPU load/store stage and the memory array, and replaces the unclocked single-width data memory.

---
 rtl/data_memory_ctrl_if.sv | 30 +++
 rtl/data_memory_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bundle for data_memory_ctrl
//   master: req_valid, req_we, req_size, req_signed, req_addr, req_wdata out;
//           req_ready, rsp_valid, rsp_rdata, rsp_err, busy in
//   slave:  the mirror image of master
interface data_memory_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - clocked big-endian byte-addressable data memory
//   clk : rising-edge clock
//   rst : synchronous active-high reset (array contents are kept)
//   bus : data_memory_ctrl_if.slave (valid/ready request, one-cycle response)
//   Optional macro DMEM_MISALIGN_SPLIT_EN: odd-address halfwords are split
//   into two byte accesses (ACCESS then ACCESS2) instead of flagging rsp_err.
module data_memory_ctrl #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH_BYTES = 64,
    parameter int WAIT_STATES = 0
) (
    input logic              clk,
    input logic              rst,
    data_memory_ctrl_if.slave bus
);
    localparam int AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int LW = ADDR_W + 1;

`ifdef DMEM_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP, S_ACCESS2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
`endif

    logic [7:0] mem [DEPTH_BYTES];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              accept;
    logic [2:0]        nbytes;
    logic [LW-1:0]     last_addr;
    logic              size_bad, misalign, out_of_range, err;
    logic              half_odd, word_mis;
    logic [AW-1:0]     a0, a1, a2, a3;
    logic [7:0]        b0, b1;
    logic [31:0]       wd32;
    logic [DATA_W-1:0] ld_data;
`ifdef DMEM_MISALIGN_SPLIT_EN
    logic              split;
`endif

    assign accept = bus.req_valid && ready_q;

    // Checks below always look at the captured request, never at the live bus.
    always_comb begin
        nbytes = 3'd1;
        case (size_q)
            2'd1:    nbytes = 3'd2;
            2'd2:    nbytes = 3'd4;
            default: nbytes = 3'd1;
        endcase
    end

    // Computed one bit wider than the address so the top of the space cannot wrap.
    assign last_addr    = {1'b0, addr_q} + LW'(nbytes) - LW'(1);
    assign out_of_range = (last_addr >= LW'(DEPTH_BYTES));
    assign size_bad     = (size_q == 2'd3) || ((size_q == 2'd2) && (DATA_W == 16));
    assign half_odd     = (size_q == 2'd1) && addr_q[0];
    assign word_mis     = (size_q == 2'd2) && (addr_q[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_SPLIT_EN
    assign misalign     = word_mis;
    assign split        = half_odd && !size_bad && !out_of_range;
`else
    assign misalign     = half_odd || word_mis;
`endif
    assign err          = size_bad || misalign || out_of_range;

    assign a0   = addr_q[AW-1:0];
    assign a1   = a0 + AW'(1);
    assign a2   = a0 + AW'(2);
    assign a3   = a0 + AW'(3);
    assign b0   = mem[a0];
    assign b1   = mem[a1];
    assign wd32 = 32'(wdata_q);

    // Lowest address is the most significant byte.
    generate
        if (DATA_W == 32) begin : g_ld32
            always_comb begin
                ld_data = '0;
                case (size_q)
                    2'd0:    ld_data = {{24{sgn_q & b0[7]}}, b0};
                    2'd1:    ld_data = {{16{sgn_q & b0[7]}}, b0, b1};
                    default: ld_data = {b0, b1, mem[a2], mem[a3]};
                endcase
            end
        end else begin : g_ld16
            always_comb begin
                ld_data = '0;
                case (size_q)
                    2'd0:    ld_data = {{8{sgn_q & b0[7]}}, b0};
                    default: ld_data = {b0, b1};
                endcase
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    sgn_d   = bus.req_signed;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                if (split) state_d = S_ACCESS2;
                else       state_d = S_RESP;
`else
                state_d = S_RESP;
`endif
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            S_ACCESS2: state_d = S_RESP;
`endif
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Response data is latched on the edge that enters RESP and then held.
        if (state_d == S_RESP) begin
            rsp_err_d   = err;
            rsp_rdata_d = (err || we_q) ? '0 : ld_data;
        end

        ready_d     = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array is never reset; rst still blocks a write landing in ACCESS.
    always_ff @(posedge clk) begin
        if (!rst && we_q && !err) begin
            if (state_q == S_ACCESS) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
                if (split) begin
                    mem[a0] <= wd32[15:8];
                end else
`endif
                case (size_q)
                    2'd0: mem[a0] <= wd32[7:0];
                    2'd1: begin
                        mem[a0] <= wd32[15:8];
                        mem[a1] <= wd32[7:0];
                    end
                    2'd2: begin
                        mem[a0] <= wd32[31:24];
                        mem[a1] <= wd32[23:16];
                        mem[a2] <= wd32[15:8];
                        mem[a3] <= wd32[7:0];
                    end
                    default: ;
                endcase
            end
`ifdef DMEM_MISALIGN_SPLIT_EN
            else if (state_q == S_ACCESS2) begin
                mem[a1] <= wd32[7:0];
            end
`endif
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - scoreboard bench for data_memory_ctrl (16-bit/0 ws and 32-bit/3 ws)
module tb_data_memory_ctrl;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic clk;
    logic rst0, rst1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(16)) b0 ();
    data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(16)) b1 ();

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_BYTES(64), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst0), .bus(b0)
    );
    data_memory_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH_BYTES(64), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst1), .bus(b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? b0.req_ready : b1.req_ready;
    endfunction

    // Monitor: pops one expectation per response pulse and checks data, error and timing.
    always @(negedge clk) begin
        exp_t e;
        if (b0.rsp_valid) begin
            if (q0.size() == 0) chk("d0_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                chk({e.name, "_rdata"}, 32'(b0.rsp_rdata), e.rdata);
                chk({e.name, "_err"}, 32'(b0.rsp_err), 32'(e.err));
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
        if (b1.rsp_valid) begin
            if (q1.size() == 0) chk("d1_unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                chk({e.name, "_rdata"}, b1.rsp_rdata, e.rdata);
                chk({e.name, "_err"}, 32'(b1.rsp_err), 32'(e.err));
                chk({e.name, "_cycle"}, cyc, e.cyc);
            end
        end
    end

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input int d, input bit we, input logic [1:0] size, input bit sgn,
                         input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input bit exp_err, input int extra,
                         input bit want_rsp, input string name);
        int   n;
        exp_t e;
        if (d == 0) begin
            b0.req_we = we; b0.req_size = size; b0.req_signed = sgn;
            b0.req_addr = addr; b0.req_wdata = wdata[15:0]; b0.req_valid = 1'b1;
        end else begin
            b1.req_we = we; b1.req_size = size; b1.req_signed = sgn;
            b1.req_addr = addr; b1.req_wdata = wdata; b1.req_valid = 1'b1;
        end
        n = 0;
        while (!rdy(d) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk({name, "_ready_timeout"}, 32'd0, 32'd1);
        end else if (want_rsp) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            e.cyc   = cyc + 2 + ((d == 0) ? 0 : 3) + extra;
            e.name  = name;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        b0.req_valid = (d == 0) ? 1'b0 : b0.req_valid;
        b1.req_valid = (d == 1) ? 1'b0 : b1.req_valid;
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (!rdy(d) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        rst0 = 1'b1; rst1 = 1'b1;
        b0.req_valid = 0; b0.req_we = 0; b0.req_size = 0; b0.req_signed = 0;
        b0.req_addr = 0; b0.req_wdata = 0;
        b1.req_valid = 0; b1.req_we = 0; b1.req_size = 0; b1.req_signed = 0;
        b1.req_addr = 0; b1.req_wdata = 0;
        repeat (3) @(negedge clk);

        chk("rst_ready0", 32'(b0.req_ready), 32'd0);
        chk("rst_rspvalid0", 32'(b0.rsp_valid), 32'd0);
        chk("rst_rdata0", 32'(b0.rsp_rdata), 32'd0);
        chk("rst_busy0", 32'(b0.busy), 32'd0);
        chk("rst_ready1", 32'(b1.req_ready), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("ready_after_rst0", 32'(b0.req_ready), 32'd1);
        chk("ready_after_rst1", 32'(b1.req_ready), 32'd1);
        chk("idle_rspvalid0", 32'(b0.rsp_valid), 32'd0);

        // 16-bit, no wait states
        issue(0, 1, 2'd1, 0, 16'h0004, 32'hA55A, 32'h0,    0, 0, 1, "st_h_04");
        issue(0, 0, 2'd1, 0, 16'h0004, 32'h0,    32'hA55A, 0, 0, 1, "ld_h_04");
        issue(0, 0, 2'd0, 1, 16'h0004, 32'h0,    32'hFFA5, 0, 0, 1, "ld_bs_04");
        issue(0, 0, 2'd0, 0, 16'h0005, 32'h0,    32'h005A, 0, 0, 1, "ld_bu_05");
        issue(0, 1, 2'd0, 0, 16'h003F, 32'h0080, 32'h0,    0, 0, 1, "st_b_3f");
        issue(0, 0, 2'd0, 1, 16'h003F, 32'h0,    32'hFF80, 0, 0, 1, "ld_bs_3f");
        issue(0, 0, 2'd1, 0, 16'h003F, 32'h0,    32'h0,    1, 0, 1, "ld_h_3f");
        issue(0, 1, 2'd1, 0, 16'h003F, 32'h1122, 32'h0,    1, 0, 1, "st_h_3f");
        issue(0, 0, 2'd0, 0, 16'h003F, 32'h0,    32'h0080, 0, 0, 1, "ld_bu_3f_kept");
        issue(0, 1, 2'd0, 0, 16'h0040, 32'h0077, 32'h0,    1, 0, 1, "st_b_40");
        issue(0, 0, 2'd0, 0, 16'h0000, 32'h0,    32'h0000, 0, 0, 1, "ld_b_00");
        issue(0, 0, 2'd2, 0, 16'h0004, 32'h0,    32'h0,    1, 0, 1, "ld_w_on16");
        issue(0, 0, 2'd3, 0, 16'h0004, 32'h0,    32'h0,    1, 0, 1, "ld_size3");
        issue(0, 1, 2'd1, 0, 16'h0007, 32'hBEEF, 32'h0,    !SPLIT, int'(SPLIT), 1, "st_h_07");
        issue(0, 0, 2'd1, 0, 16'h0007, 32'h0,    SPLIT ? 32'hBEEF : 32'h0, !SPLIT, int'(SPLIT), 1, "ld_h_07");
        issue(0, 0, 2'd0, 0, 16'h0007, 32'h0,    SPLIT ? 32'h00BE : 32'h0, 0, 0, 1, "ld_b_07");
        issue(0, 0, 2'd0, 0, 16'h0008, 32'h0,    SPLIT ? 32'h00EF : 32'h0, 0, 0, 1, "ld_b_08");

        // 32-bit, three wait states
        issue(1, 1, 2'd2, 0, 16'h0008, 32'h11223344, 32'h0,        0, 0, 1, "st_w_08");
        issue(1, 0, 2'd2, 0, 16'h0008, 32'h0,        32'h11223344, 0, 0, 1, "ld_w_08");
        issue(1, 0, 2'd0, 1, 16'h000B, 32'h0,        32'h00000044, 0, 0, 1, "ld_bs_0b");
        issue(1, 0, 2'd1, 1, 16'h0008, 32'h0,        32'h00001122, 0, 0, 1, "ld_hs_08");
        issue(1, 1, 2'd1, 0, 16'h0020, 32'h00009ABC, 32'h0,        0, 0, 1, "st_h_20");
        issue(1, 0, 2'd1, 1, 16'h0020, 32'h0,        32'hFFFF9ABC, 0, 0, 1, "ld_hs_20");
        issue(1, 0, 2'd1, 0, 16'h0020, 32'h0,        32'h00009ABC, 0, 0, 1, "ld_hu_20");
        issue(1, 0, 2'd0, 1, 16'h0021, 32'h0,        32'hFFFFFFBC, 0, 0, 1, "ld_bs_21");
        issue(1, 0, 2'd2, 0, 16'h000A, 32'h0,        32'h0,        1, 0, 1, "ld_w_0a_mis");
        issue(1, 0, 2'd2, 0, 16'h003C, 32'h0,        32'h0,        0, 0, 1, "ld_w_3c_edge");
        issue(1, 1, 2'd2, 0, 16'h0040, 32'hDEADBEEF, 32'h0,        1, 0, 1, "st_w_40");

        // req_valid held high: ready must stay low for five cycles after accept
        wait_ready(1);
        b1.req_we = 0; b1.req_size = 2'd2; b1.req_signed = 0; b1.req_addr = 16'h0008;
        b1.req_valid = 1'b1;
        q1.push_back('{rdata: 32'h11223344, err: 1'b0, cyc: cyc + 5, name: "hold_ld_w_08"});
        @(negedge clk);
        n = 0;
        while (!b1.req_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        b1.req_valid = 1'b0;
        chk("ready_low_cycles", n, 5);

        // reset while in WAIT: store must not land and no response may appear
        issue(1, 1, 2'd1, 0, 16'h0010, 32'h1234, 32'h0, 0, 0, 0, "st_h_10_abort");
        rst1 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        chk("abort_busy", 32'(b1.busy), 32'd0);
        chk("abort_rspvalid", 32'(b1.rsp_valid), 32'd0);
        issue(1, 0, 2'd1, 0, 16'h0010, 32'h0, 32'h0, 0, 0, 1, "ld_h_10_after_abort");

        repeat (20) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            chk("global_timeout", 32'd1, 32'd0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end
endmodule
